// File: rtl/stream_max_pkg.sv
// Shared definitions for the stream maximum unit: FSM encoding and
// default parameter values.
package stream_max_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_W          = 4;
    localparam int DEF_CH         = 2;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_APPROX_LSB = 2;

endpackage

// File: rtl/max_tree.sv
// Combinational reduction of one beat's lanes to its maximum value and the
// lane index holding it. Lower lanes win ties; in approximate mode the
// low APPROX_LSB bits are ignored for the compare but the original value
// is returned.
module max_tree
    import stream_max_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int CH         = DEF_CH,
    parameter int APPROX_LSB = DEF_APPROX_LSB
) (
    input  logic [CH*W-1:0]       data,
    input  logic                  approx_en,
    output logic [W-1:0]          max_val,
    output logic [$clog2(CH)-1:0] max_idx
);

    localparam int IDX_W = $clog2(CH);
    localparam logic [W-1:0] CMP_MASK = {W{1'b1}} << APPROX_LSB;

    logic [W-1:0] lane_val [CH];
    logic [W-1:0] lane_cmp [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            assign lane_val[gi] = data[gi*W +: W];
            assign lane_cmp[gi] = approx_en ? (lane_val[gi] & CMP_MASK) : lane_val[gi];
        end
    endgenerate

    // Linear scan; strict greater-than keeps the lowest index on ties
    always_comb begin
        logic [W-1:0] best_cmp;
        max_val  = lane_val[0];
        max_idx  = '0;
        best_cmp = lane_cmp[0];
        for (int k = 1; k < CH; k++) begin
            if (lane_cmp[k] > best_cmp) begin
                best_cmp = lane_cmp[k];
                max_val  = lane_val[k];
                max_idx  = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/stream_max_unit.sv
// Frame-level maximum finder: accumulates the largest lane value over a
// frame of beats and reports value, lane and beat index once per frame.
module stream_max_unit
    import stream_max_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int CH         = DEF_CH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int APPROX_LSB = DEF_APPROX_LSB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*W-1:0]       in_data,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic                  approx_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_max,
    output logic [$clog2(CH)-1:0] out_idx,
    output logic [LEN_W-1:0]      out_beat
);

    localparam int IDX_W = $clog2(CH);
    localparam logic [W-1:0] CMP_MASK = {W{1'b1}} << APPROX_LSB;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               approx_q, approx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       acc_max_q, acc_max_d;
    logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic [LEN_W-1:0]   acc_beat_q, acc_beat_d;

    logic               tree_approx;
    logic [W-1:0]       beat_max;
    logic [IDX_W-1:0]   beat_idx;
    logic [W-1:0]       beat_cmp;
    logic [W-1:0]       acc_cmp;
    logic [LEN_W-1:0]   cnt_inc;

    // The first beat uses the live approx_en; later beats the latched copy
    assign tree_approx = (state_q == ST_IDLE) ? approx_en : approx_q;

    max_tree #(
        .W          (W),
        .CH         (CH),
        .APPROX_LSB (APPROX_LSB)
    ) u_max_tree (
        .data      (in_data),
        .approx_en (tree_approx),
        .max_val   (beat_max),
        .max_idx   (beat_idx)
    );

    assign beat_cmp  = approx_q ? (beat_max & CMP_MASK) : beat_max;
    assign acc_cmp   = approx_q ? (acc_max_q & CMP_MASK) : acc_max_q;
    assign cnt_inc   = cnt_q + LEN_W'(1);

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_max   = acc_max_q;
    assign out_idx   = acc_idx_q;
    assign out_beat  = acc_beat_q;

    // Next-state, frame configuration and accumulator update
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        approx_d   = approx_q;
        cnt_d      = cnt_q;
        acc_max_d  = acc_max_q;
        acc_idx_d  = acc_idx_q;
        acc_beat_d = acc_beat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // A zero length is treated as a one-beat frame
                    len_d      = (frame_len == '0) ? LEN_W'(1) : frame_len;
                    approx_d   = approx_en;
                    cnt_d      = '0;
                    acc_max_d  = beat_max;
                    acc_idx_d  = beat_idx;
                    acc_beat_d = '0;
                    state_d    = (frame_len <= LEN_W'(1)) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    cnt_d = cnt_inc;
                    // Strictly greater: earliest beat keeps a tie
                    if (beat_cmp > acc_cmp) begin
                        acc_max_d  = beat_max;
                        acc_idx_d  = beat_idx;
                        acc_beat_d = cnt_inc;
                    end
                    if (cnt_inc == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            approx_q   <= 1'b0;
            cnt_q      <= '0;
            acc_max_q  <= '0;
            acc_idx_q  <= '0;
            acc_beat_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            approx_q   <= approx_d;
            cnt_q      <= cnt_d;
            acc_max_q  <= acc_max_d;
            acc_idx_q  <= acc_idx_d;
            acc_beat_q <= acc_beat_d;
        end
    end

endmodule

// File: tb/tb_stream_max_unit.sv
// Directed bench for stream_max_unit with hand-computed expected results.
module tb_stream_max_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] frame_len;
    logic       approx_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_max;
    logic [0:0] out_idx;
    logic [7:0] out_beat;

    int checks_cnt = 0;
    int errors_cnt = 0;

    stream_max_unit #(
        .W(4), .CH(2), .LEN_W(8), .APPROX_LSB(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .frame_len (frame_len),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_beat  (out_beat)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Present one beat, let it be accepted on the next edge, then scramble
    // the idle inputs so ignored values are exercised
    task automatic send_beat(input logic [3:0] l0, input logic [3:0] l1,
                             input logic [7:0] len, input logic apx);
        in_valid  = 1'b1;
        in_data   = {l1, l0};
        frame_len = len;
        approx_en = apx;
        #1;
        check_val("in_ready_before_beat", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        frame_len = 8'($urandom);
        approx_en = 1'($urandom);
    endtask

    task automatic expect_result(input string tag, input int unsigned mx,
                                 input int unsigned idx, input int unsigned bt);
        @(negedge clk);
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_max"},   out_max,   mx);
        check_val({tag, "_idx"},   out_idx,   idx);
        check_val({tag, "_beat"},  out_beat,  bt);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check_val({tag, "_valid0"}, out_valid, 0);
        check_val({tag, "_ready1"}, in_ready,  1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        frame_len = '0;
        approx_en = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready",  in_ready,  1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_in_ready",  in_ready,  1);
        check_val("idle_out_valid", out_valid, 0);
        check_val("idle_out_max",   out_max,   0);

        // Three-beat frame, immediately consumed
        @(posedge clk); #1;
        send_beat(4'd3, 4'd5, 8'd3, 1'b0);
        check_val("mid_frame_no_valid", out_valid, 0);
        send_beat(4'd9, 4'd2, 8'd3, 1'b0);
        send_beat(4'd7, 4'd9, 8'd3, 1'b0);
        expect_result("f3", 9, 0, 1);
        expect_idle("f3_after");

        // Same frame with downstream back-pressure for five cycles
        out_ready = 1'b0;
        @(posedge clk); #1;
        send_beat(4'd3, 4'd5, 8'd3, 1'b0);
        send_beat(4'd9, 4'd2, 8'd3, 1'b0);
        send_beat(4'd7, 4'd9, 8'd3, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            expect_result("bp", 9, 0, 1);
            check_val("bp_in_ready0", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        expect_idle("bp_after");

        // Approximate mode: 5 and 6 both mask to 4, lane 0 wins
        @(posedge clk); #1;
        send_beat(4'd5, 4'd6, 8'd1, 1'b1);
        expect_result("apx1", 5, 0, 0);
        expect_idle("apx1_after");

        // Approximate tie across beats: 8 vs 11 both mask to 8, earlier beat wins
        @(posedge clk); #1;
        send_beat(4'd8, 4'd0, 8'd2, 1'b1);
        send_beat(4'd0, 4'd11, 8'd2, 1'b0);
        expect_result("apx2", 8, 0, 0);
        expect_idle("apx2_after");

        // Zero length behaves as a single beat
        @(posedge clk); #1;
        send_beat(4'd2, 4'd11, 8'd0, 1'b0);
        expect_result("len0", 11, 1, 0);
        expect_idle("len0_after");

        // Mid-frame length change ignored; exact ties keep earliest beat/lane
        @(posedge clk); #1;
        send_beat(4'd6, 4'd2, 8'd3, 1'b0);
        send_beat(4'd1, 4'd6, 8'd1, 1'b0);
        check_val("len_change_no_valid", out_valid, 0);
        send_beat(4'd6, 4'd6, 8'd1, 1'b0);
        expect_result("tie", 6, 0, 0);
        expect_idle("tie_after");

        // Reset mid-frame discards the partial frame
        @(posedge clk); #1;
        send_beat(4'd8, 4'd1, 8'd4, 1'b0);
        send_beat(4'd15, 4'd3, 8'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_max",   out_max,   0);
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_in_ready",  in_ready,  1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_idle("midrst_after");
        @(posedge clk); #1;
        send_beat(4'd1, 4'd4, 8'd1, 1'b0);
        expect_result("post_rst", 4, 1, 0);
        expect_idle("post_rst_after");

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
